// File: rtl/eth_rx_filter.sv
// eth_rx_filter: packs RMII dibits into bytes, holds the Ethernet header in a
// 16-byte FIFO and forwards only frames for this station (or broadcast) with a kept ethertype.
module eth_rx_filter #(
    parameter logic [47:0] MYADDR  = 48'hb827eba43073,
    parameter logic [15:0] ETYPE_A = 16'h1234,
    parameter logic [15:0] ETYPE_B = 16'h0806
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_axi_valid,
    input  logic [1:0]  rx_axi_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        out_drop,
    output logic [15:0] accept_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [3:0]  HDR_LEN = 4'd14;
    localparam logic [47:0] BCAST   = 48'hffff_ffff_ffff;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PASS,
        S_DISCARD,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;

    logic [1:0]  dib_cnt_q, dib_cnt_d;
    logic [5:0]  dib_sh_q, dib_sh_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [47:0] dst_q, dst_d;
    logic [15:0] etype_q, etype_d;
    logic        vld_prev_q;
    logic        drain_seen_q, drain_seen_d;
    logic        drop_pend_q, drop_pend_d;

    logic [7:0]  fifo_mem [16];
    logic [3:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]  fifo_cnt_q, fifo_cnt_d;

    logic        out_valid_q, out_last_q;
    logic [7:0]  out_data_q, out_data_d;
    logic [15:0] accept_cnt_q, drop_cnt_q;

    logic        cap, byte_wr, hdr_wr, hdr_done, hdr_ok;
    logic [7:0]  byte_new;
    logic        pop, pop_last, flush, drop;

    function automatic logic frame_wanted(input logic [47:0] dst, input logic [15:0] et);
        return ((dst == MYADDR) || (dst == BCAST)) && ((et == ETYPE_A) || (et == ETYPE_B));
    endfunction

    // A high line seen in IDLE right after another high cycle is the tail of
    // a frame we never saw the start of, so it is not captured.
    always_comb begin
        cap       = rx_axi_valid && ((state_q == S_HDR) || (state_q == S_PASS) ||
                                     ((state_q == S_IDLE) && !vld_prev_q));
        byte_new  = {rx_axi_data, dib_sh_q};
        byte_wr   = cap && (dib_cnt_q == 2'd3);
        dib_cnt_d = cap ? dib_cnt_q + 2'd1 : 2'd0;
        dib_sh_d  = cap ? {rx_axi_data, dib_sh_q[5:2]} : dib_sh_q;
    end

    always_comb begin
        hdr_wr   = byte_wr && (state_q == S_HDR);
        hdr_done = (state_q == S_HDR) && (byte_cnt_q == HDR_LEN);
        hdr_ok   = frame_wanted(dst_q, etype_q);

        byte_cnt_d = byte_cnt_q;
        if (state_q == S_IDLE)
            byte_cnt_d = 4'd0;
        else if (byte_wr && (byte_cnt_q != HDR_LEN))
            byte_cnt_d = byte_cnt_q + 4'd1;

        dst_d   = (hdr_wr && (byte_cnt_q < 4'd6)) ? {dst_q[39:0], byte_new} : dst_q;
        etype_d = (hdr_wr && ((byte_cnt_q == 4'd12) || (byte_cnt_q == 4'd13)))
                  ? {etype_q[7:0], byte_new} : etype_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_axi_valid)
                    state_d = vld_prev_q ? S_DISCARD : S_HDR;
            end
            S_HDR: begin
                if (hdr_done) begin
                    if (hdr_ok)
                        state_d = rx_axi_valid ? S_PASS : S_DRAIN;
                    else
                        state_d = rx_axi_valid ? S_DISCARD : S_IDLE;
                end else if (!rx_axi_valid) begin
                    state_d = S_IDLE;
                end
            end
            S_PASS: begin
                if (!rx_axi_valid)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_last_q)
                    state_d = (drain_seen_q || rx_axi_valid) ? S_DISCARD : S_IDLE;
            end
            S_DISCARD: begin
                if (!rx_axi_valid)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // PASS keeps one byte back so the true final byte can still carry out_last
    // when the frame ends on a partial byte.
    always_comb begin
        drop     = 1'b0;
        pop      = 1'b0;
        pop_last = 1'b0;
        case (state_q)
            S_HDR:     drop = hdr_done ? !hdr_ok : !rx_axi_valid;
            S_PASS:    pop  = (fifo_cnt_q > 5'd1);
            S_DRAIN: begin
                pop      = (fifo_cnt_q != 5'd0);
                pop_last = (fifo_cnt_q == 5'd1);
            end
            S_DISCARD: drop = !rx_axi_valid && drop_pend_q;
            default: ;
        endcase
        flush = (state_q == S_HDR) && drop;
    end

    always_comb begin
        wr_ptr_d     = flush ? 4'd0 : wr_ptr_q + 4'(byte_wr);
        rd_ptr_d     = flush ? 4'd0 : rd_ptr_q + 4'(pop);
        fifo_cnt_d   = flush ? 5'd0 : fifo_cnt_q + 5'(byte_wr) - 5'(pop);
        out_data_d   = pop ? fifo_mem[rd_ptr_q] : out_data_q;
        drain_seen_d = (state_q == S_DRAIN) && (drain_seen_q || rx_axi_valid);
        if (state_q == S_DRAIN)
            drop_pend_d = (state_d == S_DISCARD);
        else
            drop_pend_d = (state_q == S_DISCARD) && drop_pend_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dib_cnt_q    <= 2'd0;
            byte_cnt_q   <= 4'd0;
            vld_prev_q   <= 1'b1;
            drain_seen_q <= 1'b0;
            drop_pend_q  <= 1'b0;
            wr_ptr_q     <= 4'd0;
            rd_ptr_q     <= 4'd0;
            fifo_cnt_q   <= 5'd0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= 8'd0;
            accept_cnt_q <= 16'd0;
            drop_cnt_q   <= 16'd0;
        end else begin
            dib_cnt_q    <= dib_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            vld_prev_q   <= rx_axi_valid;
            drain_seen_q <= drain_seen_d;
            drop_pend_q  <= drop_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            out_valid_q  <= pop;
            out_last_q   <= pop_last;
            out_data_q   <= out_data_d;
            accept_cnt_q <= accept_cnt_q + 16'(pop_last);
            drop_cnt_q   <= drop_cnt_q + 16'(drop);
        end
    end

    always_ff @(posedge clk) begin
        dib_sh_q <= dib_sh_d;
        dst_q    <= dst_d;
        etype_q  <= etype_d;
        if (byte_wr && !flush)
            fifo_mem[wr_ptr_q] <= byte_new;
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign out_drop   = drop;
    assign accept_cnt = accept_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_filter.sv
// Directed bench for eth_rx_filter: a table of frames with hand-derived outcomes,
// then back-to-back, reset-mid-frame and reset-state sequences.
module tb_eth_rx_filter;

    localparam logic [47:0] MYADDR = 48'hb827eba43073;
    localparam logic [47:0] BCAST  = 48'hffffffffffff;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_axi_valid = 1'b0;
    logic [1:0]  rx_axi_data = 2'b00;
    logic        out_valid, out_last, out_drop;
    logic [7:0]  out_data;
    logic [15:0] accept_cnt, drop_cnt;

    eth_rx_filter #(
        .MYADDR (MYADDR),
        .ETYPE_A(16'h1234),
        .ETYPE_B(16'h0806)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_axi_valid(rx_axi_valid),
        .rx_axi_data (rx_axi_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_drop    (out_drop),
        .accept_cnt  (accept_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    logic [7:0] outq[$];
    int         outcyc[$];
    int mon_nlast = 0, mon_last_idx = 0, mon_ndrop = 0, mon_drop_cyc = 0, mon_coinc = 0;

    always @(negedge clk) begin
        if (out_valid) begin
            outq.push_back(out_data);
            outcyc.push_back(cyc);
            if (out_last) begin
                mon_nlast    <= mon_nlast + 1;
                mon_last_idx <= outq.size() - 1;
            end
        end
        if (out_drop) begin
            mon_ndrop    <= mon_ndrop + 1;
            mon_drop_cyc <= cyc;
        end
        if (out_drop && out_valid)
            mon_coinc <= mon_coinc + 1;
    end

    typedef struct {
        logic [47:0] dst;
        logic [15:0] et;
        int          nbytes;
        int          xdib;
        bit          acc;
    } vec_t;

    logic [7:0] fb [2][128];
    int nvec = 0, nmis = 0;
    int drv_e13 = 0, drv_end = 0;
    int exp_acc = 0, exp_drp = 0;

    task automatic check(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic build_frame(input int sel, input logic [47:0] dst, input logic [15:0] et,
                               input int seed);
        for (int i = 0; i < 128; i++) begin
            if (i < 6)        fb[sel][i] = dst[47-8*i -: 8];
            else if (i < 12)  fb[sel][i] = 8'(8'h10 + i);
            else if (i == 12) fb[sel][i] = et[15:8];
            else if (i == 13) fb[sel][i] = et[7:0];
            else              fb[sel][i] = 8'(i * 37 + seed);
        end
    endtask

    task automatic drive_frame(input int sel, input int nbytes, input int xdib, input int rst_at);
        logic [7:0] byt;
        for (int b = 0; b < nbytes; b++) begin
            byt = fb[sel][b];
            for (int d = 0; d < 4; d++) begin
                @(posedge clk); #1;
                if (b == rst_at && d == 0) begin
                    rst = 1'b1;
                    #1;
                    check("rst_mid out_valid", out_valid, 0);
                    check("rst_mid out_last", out_last, 0);
                    check("rst_mid out_drop", out_drop, 0);
                    check("rst_mid out_data", out_data, 0);
                    check("rst_mid accept_cnt", accept_cnt, 0);
                    check("rst_mid drop_cnt", drop_cnt, 0);
                    rst = 1'b0;
                end
                rx_axi_valid = 1'b1;
                rx_axi_data  = byt[2*d +: 2];
                if (b == 13 && d == 3) drv_e13 = cyc + 1;
            end
        end
        for (int d = 0; d < xdib; d++) begin
            @(posedge clk); #1;
            rx_axi_valid = 1'b1;
            rx_axi_data  = 2'b10;
        end
        @(posedge clk); #1;
        rx_axi_valid = 1'b0;
        drv_end = cyc;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int s_nout, s_nlast, s_ndrop, s_coinc, bad, nout;
        build_frame(0, v.dst, v.et, idx * 11);
        s_nout  = outq.size();
        s_nlast = mon_nlast;
        s_ndrop = mon_ndrop;
        s_coinc = mon_coinc;
        drive_frame(0, v.nbytes, v.xdib, -1);
        repeat (40) @(posedge clk);
        #1;
        if (v.acc) exp_acc++; else exp_drp++;
        nout = outq.size() - s_nout;
        check($sformatf("v%0d out_bytes", idx), nout, v.acc ? v.nbytes : 0);
        check($sformatf("v%0d out_last_count", idx), mon_nlast - s_nlast, v.acc ? 1 : 0);
        check($sformatf("v%0d drop_pulses", idx), mon_ndrop - s_ndrop, v.acc ? 0 : 1);
        check($sformatf("v%0d drop_with_valid", idx), mon_coinc - s_coinc, 0);
        check($sformatf("v%0d accept_cnt", idx), accept_cnt, exp_acc);
        check($sformatf("v%0d drop_cnt", idx), drop_cnt, exp_drp);
        if (v.acc) begin
            bad = 0;
            for (int k = 0; k < v.nbytes; k++)
                if (k >= nout || outq[s_nout + k] !== fb[0][k]) bad++;
            check($sformatf("v%0d payload_bad_bytes", idx), bad, 0);
            check($sformatf("v%0d last_index", idx), mon_last_idx - s_nout, v.nbytes - 1);
            if (nout > 0)
                check($sformatf("v%0d byte0_latency", idx), outcyc[s_nout] - drv_e13, 2);
            else
                check($sformatf("v%0d byte0_present", idx), 0, 1);
        end else begin
            check($sformatf("v%0d drop_cycle", idx), mon_drop_cyc,
                  (v.nbytes >= 14) ? drv_e13 : drv_end);
        end
    endtask

    initial begin
        vec_t vt[9];
        int s_nout, s_nlast, s_ndrop, bad;
        vt[0] = '{MYADDR,             16'h1234, 64, 0, 1'b1};
        vt[1] = '{BCAST,              16'h0806, 60, 0, 1'b1};
        vt[2] = '{48'h020000000001,   16'h1234, 64, 0, 1'b0};
        vt[3] = '{MYADDR,             16'h0800, 60, 0, 1'b0};
        vt[4] = '{MYADDR,             16'h1234, 10, 0, 1'b0};
        vt[5] = '{MYADDR,             16'h1234,  2, 1, 1'b0};
        vt[6] = '{MYADDR,             16'h0806, 14, 0, 1'b1};
        vt[7] = '{BCAST,              16'h1234, 61, 3, 1'b1};
        vt[8] = '{48'hfffffffffffe,   16'h0806, 60, 0, 1'b0};

        #1 rst = 1'b1;
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_last", out_last, 0);
        check("reset out_drop", out_drop, 0);
        check("reset out_data", out_data, 0);
        check("reset accept_cnt", accept_cnt, 0);
        check("reset drop_cnt", drop_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 9; i++)
            run_vec(i, vt[i]);

        // Second frame starts while the first is still draining.
        build_frame(0, MYADDR, 16'h1234, 5);
        build_frame(1, BCAST, 16'h0806, 9);
        s_nout  = outq.size();
        s_nlast = mon_nlast;
        s_ndrop = mon_ndrop;
        drive_frame(0, 64, 0, -1);
        @(posedge clk);
        drive_frame(1, 60, 0, -1);
        repeat (40) @(posedge clk);
        #1;
        exp_acc++;
        exp_drp++;
        check("b2b out_bytes", outq.size() - s_nout, 64);
        bad = 0;
        for (int k = 0; k < 64; k++)
            if (s_nout + k >= outq.size() || outq[s_nout + k] !== fb[0][k]) bad++;
        check("b2b payload_bad_bytes", bad, 0);
        check("b2b out_last_count", mon_nlast - s_nlast, 1);
        check("b2b last_index", mon_last_idx - s_nout, 63);
        check("b2b drop_pulses", mon_ndrop - s_ndrop, 1);
        check("b2b drop_cycle", mon_drop_cyc, drv_end);
        check("b2b accept_cnt", accept_cnt, exp_acc);
        check("b2b drop_cnt", drop_cnt, exp_drp);

        // Reset lands at byte 30 of a frame that would be accepted.
        build_frame(0, MYADDR, 16'h1234, 3);
        s_nlast = mon_nlast;
        s_ndrop = mon_ndrop;
        drive_frame(0, 64, 0, 30);
        repeat (40) @(posedge clk);
        #1;
        exp_acc = 0;
        exp_drp = 0;
        check("rst_frame out_last_count", mon_nlast - s_nlast, 0);
        check("rst_frame drop_pulses", mon_ndrop - s_ndrop, 0);
        check("rst_frame accept_cnt", accept_cnt, 0);
        check("rst_frame drop_cnt", drop_cnt, 0);
        run_vec(9, vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
